adc_spi_responder: RTL

Synthesizable responder for the 8-channel, 12-bit ADC serial interface (16 SCLK frame, 3-bit address on DIN, 4 leading zeros + 12 data bits on DOUT). It emulates the ADC at the far end of the serial link, so the ADC controller and downstream logic can be exercised on the board or in simulation without the converter fitted. Channel values come from a parallel input bus driven by test logic or a pattern generator. Serial pins are oversampled on the system clock.

---
 rtl/adc_spi_responder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
//
// Emulates an 8-channel, 12-bit serial ADC on the far side of an SPI-style
// link. Each 16-SCLK frame returns 4 leading zeros followed by the 12-bit
// value of the channel addressed in the previous frame, MSB first. The
// address for the next frame is taken from DIN bits sampled on the rising
// edges where the edge counter reads 3, 4 and 5. The serial pins are
// oversampled on iCLK, which must run at least 8x the SCLK rate.
//
// Ports
//   iRST        async active-low reset
//   iCLK        system clock
//   iCS_n       chip select from master (async, active low)
//   iSCLK       serial clock from master (async, idles high)
//   iDIN        serial control word from master
//   iCH_DATA    channel values, ch n = iCH_DATA[12n+11:12n]
//   oDOUT       serial data, MSB first, 0 when idle
//   oDOUT_OE    pad output enable, high while a frame is active
//   oCH         address committed by the last complete frame
//   oFRAME_DONE one-cycle pulse per complete 16-bit frame
//   oERR        one-cycle pulse when CS is released mid-frame
//
// Build option
//   ADC_RESP_NOISE_EN  when defined, a 16-bit Fibonacci LFSR (taps
//                      16,14,13,11, seed 16'hACE1) perturbs bits 1:0 of every
//                      snapshotted sample; when undefined samples are exact.
// -----------------------------------------------------------------------------
module adc_spi_responder (
    input  logic        iRST,
    input  logic        iCLK,
    input  logic        iCS_n,
    input  logic        iSCLK,
    input  logic        iDIN,
    input  logic [95:0] iCH_DATA,
    output logic        oDOUT,
    output logic        oDOUT_OE,
    output logic [2:0]  oCH,
    output logic        oFRAME_DONE,
    output logic        oERR
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Unpack the channel bus so a channel can be selected by address.
    logic [11:0] ch_arr [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            assign ch_arr[gi] = iCH_DATA[12*gi +: 12];
        end
    endgenerate

    // 2-FF synchronizers plus one more stage for edge detection.
    // The CS chain resets low: if the master is mid-frame when reset is
    // released, no CS fall is seen, so the remainder of that frame is ignored
    // instead of being mistaken for a fresh (and then short) frame.
    logic [1:0] cs_sync_q;
    logic [1:0] sclk_sync_q;
    logic [1:0] din_sync_q;
    logic       cs_prev_q;
    logic       sclk_prev_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cs_sync_q   <= 2'b00;
            cs_prev_q   <= 1'b0;
            sclk_sync_q <= 2'b11;
            sclk_prev_q <= 1'b1;
            din_sync_q  <= 2'b00;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], iCS_n};
            cs_prev_q   <= cs_sync_q[1];
            sclk_sync_q <= {sclk_sync_q[0], iSCLK};
            sclk_prev_q <= sclk_sync_q[1];
            din_sync_q  <= {din_sync_q[0], iDIN};
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, din_s;
    assign cs_fall   =  cs_prev_q   & ~cs_sync_q[1];
    assign cs_rise   = ~cs_prev_q   &  cs_sync_q[1];
    assign sclk_rise = ~sclk_prev_q &  sclk_sync_q[1];
    assign sclk_fall =  sclk_prev_q & ~sclk_sync_q[1];
    assign din_s     =  din_sync_q[1];

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] sr_q, sr_d;
    // Only the control bits that can still reach the address field need to
    // be kept; before the 16th rise ADD2..ADD0 sit in bits 11:9.
    logic [11:0] ctl_q, ctl_d;
    logic [2:0]  addr_q, addr_d;
    logic        dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        frame_end;
    logic [2:0]  addr_new;
    logic [1:0]  noise;
    logic [11:0] sample_cur, sample_new;

    // CS edges win over a coincident SCLK edge, so frame_end excludes them.
    assign frame_end  = (state_q == ST_ACTIVE) & sclk_rise & (cnt_q == 5'd15)
                        & ~cs_fall & ~cs_rise;
    assign addr_new   = ctl_q[11:9];
    assign sample_cur = ch_arr[addr_q]   ^ {10'b0, noise};
    assign sample_new = ch_arr[addr_new] ^ {10'b0, noise};

`ifdef ADC_RESP_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        snap_en;

    // Advance once per snapshot, after its LSBs have been applied.
    assign snap_en = cs_fall | frame_end;
    always_comb begin
        lfsr_d = lfsr_q;
        if (snap_en) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise = lfsr_q[1:0];
`else
    assign noise = 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ctl_d   = ctl_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (cs_fall) begin
            state_d = ST_ACTIVE;
            cnt_d   = 5'd0;
            ctl_d   = 12'd0;
            sr_d    = {4'b0, sample_cur};
            oe_d    = 1'b1;
        end else if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            oe_d    = 1'b0;
            // cnt of 0 means the last frame completed cleanly.
            if (state_q == ST_ACTIVE && cnt_q != 5'd0) begin
                err_d = 1'b1;
            end
        end else if (state_q == ST_ACTIVE) begin
            if (sclk_rise) begin
                ctl_d = {ctl_q[10:0], din_s};
                if (frame_end) begin
                    addr_d = addr_new;
                    cnt_d  = 5'd0;
                    done_d = 1'b1;
                    sr_d   = {4'b0, sample_new};
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end else if (sclk_fall && cnt_q != 5'd0) begin
                // The fall before the first rise keeps the leading zero.
                sr_d = {sr_q[14:0], 1'b0};
            end
        end

        dout_d = (state_d == ST_ACTIVE) ? sr_d[15] : 1'b0;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            sr_q    <= 16'd0;
            ctl_q   <= 12'd0;
            addr_q  <= 3'd0;
            dout_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ctl_q   <= ctl_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign oDOUT       = dout_q;
    assign oDOUT_OE    = oe_q;
    assign oCH         = addr_q;
    assign oFRAME_DONE = done_q;
    assign oERR        = err_q;

endmodule
